// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one external magnitude comparator among N_REQ requesters.
// Operands go to the comparator from registers; the result returns tagged with the requester index.
module comparator_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       cmp_a,
    output logic [WIDTH-1:0]       cmp_b,
    input  logic                   cmp_gt,
    input  logic                   cmp_lt,
    input  logic                   cmp_eq,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_gt,
    output logic                   rsp_lt,
    output logic                   rsp_eq,
    output logic                   busy,
    output logic                   err_onehot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic            grant_found;
    logic            accept;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; EVAL always lasts exactly one cycle
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_found) state_next = EVAL;
            EVAL:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Round-robin search starting just after the last grant; req_ready is combinational
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_grant) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        req_ready = '0;
        if (resetn && (state == IDLE) && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = (state == IDLE) && grant_found;

    // Registered datapath and status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp_a      <= '0;
            cmp_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_gt     <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
            busy       <= 1'b0;
            err_onehot <= 1'b0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            rsp_valid <= (state_next == RESP);
            busy      <= (state_next != IDLE);
            if (accept) begin
                cmp_a      <= req_a[32'(grant_id) * WIDTH +: WIDTH];
                cmp_b      <= req_b[32'(grant_id) * WIDTH +: WIDTH];
                rsp_id     <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EVAL) begin
                rsp_gt <= cmp_gt;
                rsp_lt <= cmp_lt;
                rsp_eq <= cmp_eq;
                // Sticky until reset: a healthy comparator raises exactly one flag
                if (!$onehot({cmp_gt, cmp_lt, cmp_eq})) begin
                    err_onehot <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_comparator_arbiter.sv
// Self-checking bench for comparator_arbiter: directed vector table plus hand-written
// sequences for round-robin, backpressure, sparse grants, flag faults and mid-op reset.
module tb_comparator_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 2;

    logic             clk;
    logic             resetn;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     cmp_a;
    logic [W-1:0]     cmp_b;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic             rsp_gt;
    logic             rsp_lt;
    logic             rsp_eq;
    logic             busy;
    logic             err_onehot;
    logic             force_bad;

    int pass_cnt  = 0;
    int total_cnt = 0;

    comparator_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_gt     (cmp_gt),
        .cmp_lt     (cmp_lt),
        .cmp_eq     (cmp_eq),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_gt     (rsp_gt),
        .rsp_lt     (rsp_lt),
        .rsp_eq     (rsp_eq),
        .busy       (busy),
        .err_onehot (err_onehot)
    );

    // Behavioural stand-in for the shared comparator; force_bad breaks the one-hot property
    assign cmp_gt = force_bad | (cmp_a > cmp_b);
    assign cmp_lt = !force_bad & (cmp_a < cmp_b);
    assign cmp_eq = force_bad | (cmp_a == cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        gt;
        logic        lt;
        logic        eq;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req_valid = '0;
        tick();
        resetn = 1'b1;
        #1;
    endtask

    // One isolated request from requester id with rsp_ready held high
    task automatic run_txn(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic gt, input logic lt, input logic eq, input string tag);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid = N'(32'd1 << id);
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1 << id);
        tick();
        req_valid = '0;
        #1;
        chk({tag, "_busy_eval"}, 32'(busy), 32'd1);
        chk({tag, "_cmp_a"}, cmp_a, a);
        chk({tag, "_cmp_b"}, cmp_b, b);
        chk({tag, "_valid_eval"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_flags"}, 32'({rsp_gt, rsp_lt, rsp_eq}), 32'({gt, lt, eq}));
        tick();
        chk({tag, "_valid_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   last_cyc;
        int   rr_order[5];

        vecs[0] = '{0, 32'd100,        32'd5,          1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1};
        vecs[2] = '{2, 32'h0000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{3, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 32'd7,          32'd7,          1'b0, 1'b0, 1'b1};
        vecs[5] = '{1, 32'd3,          32'd4,          1'b0, 1'b1, 1'b0};
        rr_order = '{0, 1, 2, 3, 0};

        // Reset with random inputs
        force_bad = 1'b0;
        resetn    = 1'b0;
        req_valid = N'($urandom()) | N'(1);
        req_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
        rsp_ready = 1'($urandom());
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cmp_a", cmp_a, 32'd0);
        chk("rst_cmp_b", cmp_b, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_onehot), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        resetn    = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].lt, vecs[i].eq,
                    $sformatf("vec%0d", i));
        end

        // Round-robin with all requesters valid: order 0,1,2,3,0 spaced 3 cycles
        do_reset();
        for (int i = 0; i < int'(N); i++) begin
            req_a[i*W +: W] = 32'(i * 10);
            req_b[i*W +: W] = 32'd15;
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        n = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (req_ready != '0 && n < 5) begin
                chk($sformatf("rr_grant%0d", n), 32'(req_ready), 32'd1 << rr_order[n]);
                if (n > 0) chk($sformatf("rr_gap%0d", n), 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                n++;
            end
            tick();
        end
        chk("rr_count", 32'(n), 32'd5);
        req_valid = '0;
        tick();
        tick();
        tick();

        // Sparse requests after last_grant = 1: grant 3 then 1
        do_reset();
        run_txn(1, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, "sp_pre");
        req_valid = 4'b1010;
        #1;
        chk("sp_ready3", 32'(req_ready), 32'b1000);
        tick();
        tick();
        chk("sp_id3", 32'(rsp_id), 32'd3);
        tick();
        chk("sp_ready1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        chk("sp_id1", 32'(rsp_id), 32'd1);
        tick();

        // Backpressure: 5 cycles in RESP with rsp_ready low
        rsp_ready = 1'b0;
        req_a[2*W +: W] = 32'd1;
        req_b[2*W +: W] = 32'd2;
        req_valid = 4'b0100;
        #1;
        chk("bp_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0001;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_id%0d", c), 32'(rsp_id), 32'd2);
            chk($sformatf("bp_flags%0d", c), 32'({rsp_gt, rsp_lt, rsp_eq}), 32'b010);
            chk($sformatf("bp_busy%0d", c), 32'(busy), 32'd1);
            chk($sformatf("bp_noready%0d", c), 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_valid_done", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        // Non-one-hot comparator flags set a sticky error
        force_bad = 1'b1;
        run_txn(0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1, "bad");
        force_bad = 1'b0;
        chk("err_set", 32'(err_onehot), 32'd1);
        run_txn(1, 32'd9, 32'd2, 1'b1, 1'b0, 1'b0, "after_bad");
        chk("err_sticky", 32'(err_onehot), 32'd1);
        do_reset();
        chk("err_cleared", 32'(err_onehot), 32'd0);

        // Reset during EVAL abandons the request
        req_a[2*W +: W] = 32'd8;
        req_b[2*W +: W] = 32'd1;
        req_valid = 4'b0100;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        resetn    = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("mid_novalid%0d", c), 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
